// File: rtl/pc_gen_unit_pkg.sv
// pc_gen_unit_pkg
//   Shared encodings for the IF-stage PC generator:
//   - npc_op codes driven by EX (unchanged from the original next-PC mux)
//   - request-source encoding used by the next-PC priority logic
//   - helper to classify an npc_op as a non-sequential request
package pc_gen_unit_pkg;

  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  // Winning request source for the current cycle, lowest to highest priority.
  typedef enum logic [2:0] {
    SRC_PLUS4    = 3'd0,
    SRC_NEW      = 3'd1,
    SRC_PEND     = 3'd2,
    SRC_MISALIGN = 3'd3,
    SRC_TRAP     = 3'd4
  } req_src_e;

  // Any code other than the three redirecting ones behaves as PLUS4.
  function automatic logic is_redirect_op(input logic [2:0] op);
    return (op == NPC_BRANCH) || (op == NPC_JUMP) || (op == NPC_JALR);
  endfunction

endpackage

// File: rtl/pc_gen_unit_target.sv
// npc_target_calc
//   Combinational redirect target computation.
//   Ports:
//     npc_op      in   3     next-PC operation from EX
//     pc_ex       in   XLEN  PC of the EX-stage instruction
//     imm         in   XLEN  branch/jump immediate
//     aluout      in   XLEN  JALR target (rs1+imm)
//     target      out  XLEN  redirect target (JALR bit0 already cleared)
//     is_redirect out  1     npc_op is BRANCH/JUMP/JALR
//     misaligned  out  1     redirect target violates ALIGN_BITS alignment
module npc_target_calc
  import pc_gen_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ALIGN_BITS = 2
) (
  input  logic [2:0]      npc_op,
  input  logic [XLEN-1:0] pc_ex,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] aluout,
  output logic [XLEN-1:0] target,
  output logic            is_redirect,
  output logic            misaligned
);

  always_comb begin
    target = pc_ex + imm;
    if (npc_op == NPC_JALR) begin
      target = {aluout[XLEN-1:1], 1'b0};
    end
  end

  assign is_redirect = is_redirect_op(npc_op);

  // Checked after the JALR LSB clear, so with ALIGN_BITS=1 a JALR can never trap.
  assign misaligned = is_redirect && (target[ALIGN_BITS-1:0] != '0);

endmodule

// File: rtl/pc_gen_unit.sv
// pc_gen_unit
//   IF-stage PC register with next-PC selection, a pending-redirect latch
//   that survives stalls, trap redirection and misaligned-target trapping.
//   Ports:
//     clk, rst       clock (rising edge), synchronous active-high reset
//     pc_write       1 = PC may advance, 0 = stall
//     npc_op         next-PC op from EX
//     pc_ex, imm     branch/jump base and offset
//     aluout         JALR target
//     trap_req       trap redirect request, target trap_vec
//     pc             registered fetch PC
//     pc_plus4       pc+4 (combinational, wraps)
//     redirect       1-cycle pulse: PC loaded non-sequentially
//     misalign       1-cycle pulse: misaligned target turned into a trap
//     misalign_addr  last offending target
//     pend_valid     a redirect is latched awaiting pc_write
//   Handshake: pc_write acts as the ready for every redirect source; a
//   request seen while pc_write=0 is held in the pending latch until the
//   first cycle with pc_write=1, where it is consumed and the latch cleared.
module pc_gen_unit
  import pc_gen_unit_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = '0,
  parameter int              ALIGN_BITS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write,
  input  logic [2:0]      npc_op,
  input  logic [XLEN-1:0] pc_ex,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] aluout,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_vec,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            redirect,
  output logic            misalign,
  output logic [XLEN-1:0] misalign_addr,
  output logic            pend_valid
);

  logic [XLEN-1:0] target;
  logic            is_redirect;
  logic            misaligned;
  logic [XLEN-1:0] pend_target;
  req_src_e        src;
  logic [XLEN-1:0] sel_target;

  npc_target_calc #(
    .XLEN       (XLEN),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_target (
    .npc_op      (npc_op),
    .pc_ex       (pc_ex),
    .imm         (imm),
    .aluout      (aluout),
    .target      (target),
    .is_redirect (is_redirect),
    .misaligned  (misaligned)
  );

  assign pc_plus4 = pc + XLEN'(4);

  // Priority: trap > misaligned target > pending > new redirect > PLUS4.
  // The pending target beats a new npc_op because it is older; the new one
  // is dropped since the redirect pulse flushes EX anyway.
  always_comb begin
    src        = SRC_PLUS4;
    sel_target = pc_plus4;
    if (trap_req) begin
      src        = SRC_TRAP;
      sel_target = trap_vec;
    end else if (misaligned) begin
      src        = SRC_MISALIGN;
      sel_target = trap_vec;
    end else if (pend_valid) begin
      src        = SRC_PEND;
      sel_target = pend_target;
    end else if (is_redirect) begin
      src        = SRC_NEW;
      sel_target = target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_VEC;
      redirect      <= 1'b0;
      misalign      <= 1'b0;
      misalign_addr <= '0;
      pend_valid    <= 1'b0;
      pend_target   <= '0;
    end else begin
      redirect <= 1'b0;
      misalign <= 1'b0;

      // A misaligned target pulses whether it is applied now or latched.
      if (src == SRC_MISALIGN) begin
        misalign      <= 1'b1;
        misalign_addr <= target;
      end

      if (pc_write) begin
        pc         <= sel_target;
        redirect   <= (src != SRC_PLUS4);
        // Any pending entry is either consumed here or superseded by a trap.
        pend_valid <= 1'b0;
      end else if ((src != SRC_PLUS4) &&
                   (!pend_valid || src == SRC_TRAP || src == SRC_MISALIGN)) begin
        // Once latched, only trap-class requests may overwrite the entry.
        pend_target <= sel_target;
        pend_valid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_gen_unit.sv
// tb_pc_gen_unit
//   Two instances share one stimulus stream: u_dut0 with ALIGN_BITS=2,
//   u_dut1 with ALIGN_BITS=1. Per-instance expected outputs are queued by
//   the driver and popped by an independent monitor every cycle.
module tb_pc_gen_unit;

  localparam int XLEN = 32;
  localparam int W    = 3 * XLEN + 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            pc_write;
  logic [2:0]      npc_op;
  logic [XLEN-1:0] pc_ex, imm, aluout, trap_vec;
  logic            trap_req;

  logic [XLEN-1:0] pc0, pcp0, maddr0, pc1, pcp1, maddr1;
  logic            red0, mis0, pend0, red1, mis1, pend1;

  int tests_run = 0;
  int fail_cnt  = 0;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  // reference model state, one slot per instance
  logic [XLEN-1:0] m_pc[2], m_maddr[2], m_ptgt[2];
  logic            m_pend[2];

  always #5 clk = ~clk;

  pc_gen_unit #(.XLEN(XLEN), .RESET_VEC(32'h0), .ALIGN_BITS(2)) u_dut0 (
    .clk(clk), .rst(rst), .pc_write(pc_write), .npc_op(npc_op), .pc_ex(pc_ex),
    .imm(imm), .aluout(aluout), .trap_req(trap_req), .trap_vec(trap_vec),
    .pc(pc0), .pc_plus4(pcp0), .redirect(red0), .misalign(mis0),
    .misalign_addr(maddr0), .pend_valid(pend0)
  );

  pc_gen_unit #(.XLEN(XLEN), .RESET_VEC(32'h0), .ALIGN_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .pc_write(pc_write), .npc_op(npc_op), .pc_ex(pc_ex),
    .imm(imm), .aluout(aluout), .trap_req(trap_req), .trap_vec(trap_vec),
    .pc(pc1), .pc_plus4(pcp1), .redirect(red1), .misalign(mis1),
    .misalign_addr(maddr1), .pend_valid(pend1)
  );

  // Reference model: what the instance should show after the coming edge.
  function automatic logic [W-1:0] model_step(input int k, input int align);
    logic [XLEN-1:0] tgt, req_tgt, nxt;
    logic            is_red, mis_tgt, has_req, red, mis;
    int              kind; // 0 none, 1 new, 2 pending, 3 misaligned, 4 trap
    is_red  = (npc_op == 3'b001) || (npc_op == 3'b010) || (npc_op == 3'b100);
    tgt     = (npc_op == 3'b100) ? (aluout & ~32'h1) : (pc_ex + imm);
    mis_tgt = is_red && ((tgt % (32'h1 << align)) != 0);
    red = 1'b0;
    mis = 1'b0;
    if (rst) begin
      m_pc[k] = 32'h0; m_maddr[k] = 32'h0; m_ptgt[k] = 32'h0; m_pend[k] = 1'b0;
    end else begin
      kind = 0; req_tgt = 32'h0;
      if (trap_req)       begin kind = 4; req_tgt = trap_vec;  end
      else if (mis_tgt)   begin kind = 3; req_tgt = trap_vec;  end
      else if (m_pend[k]) begin kind = 2; req_tgt = m_ptgt[k]; end
      else if (is_red)    begin kind = 1; req_tgt = tgt;       end
      has_req = (kind != 0);
      if (kind == 3) begin
        mis = 1'b1;
        m_maddr[k] = tgt;
      end
      if (pc_write) begin
        nxt = has_req ? req_tgt : m_pc[k] + 32'd4;
        m_pc[k] = nxt;
        red = has_req;
        m_pend[k] = 1'b0;
      end else if (has_req && (!m_pend[k] || kind >= 3)) begin
        m_ptgt[k] = req_tgt;
        m_pend[k] = 1'b1;
      end
    end
    return {m_pc[k], m_pc[k] + 32'd4, m_maddr[k], red, mis, m_pend[k]};
  endfunction

  // Driver: inputs are already set; queue expectations, then cross the edge.
  task automatic step();
    exp_q0.push_back(model_step(0, 2));
    exp_q1.push_back(model_step(1, 1));
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic r, input logic w, input logic [2:0] op,
                        input logic [XLEN-1:0] pe, input logic [XLEN-1:0] im,
                        input logic [XLEN-1:0] al, input logic tr,
                        input logic [XLEN-1:0] tv);
    rst = r; pc_write = w; npc_op = op; pc_ex = pe; imm = im;
    aluout = al; trap_req = tr; trap_vec = tv;
  endtask

  task automatic chk(input string name, input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] req);
    tests_run++;
    if (act !== req) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare one queued entry per edge.
  always @(posedge clk) begin
    logic [W-1:0] e, a;
    #1;
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      a = {pc0, pcp0, maddr0, red0, mis0, pend0};
      tests_run++;
      if (a !== e) begin
        fail_cnt++;
        $display("FAIL sb_a2 @%0t: got pc=%h p4=%h ma=%h red=%b mis=%b pend=%b expected pc=%h p4=%h ma=%h red=%b mis=%b pend=%b",
                 $time, a[W-1-:32], a[W-33-:32], a[W-65-:32], a[2], a[1], a[0],
                 e[W-1-:32], e[W-33-:32], e[W-65-:32], e[2], e[1], e[0]);
      end
    end
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      a = {pc1, pcp1, maddr1, red1, mis1, pend1};
      tests_run++;
      if (a !== e) begin
        fail_cnt++;
        $display("FAIL sb_a1 @%0t: got pc=%h p4=%h ma=%h red=%b mis=%b pend=%b expected pc=%h p4=%h ma=%h red=%b mis=%b pend=%b",
                 $time, a[W-1-:32], a[W-33-:32], a[W-65-:32], a[2], a[1], a[0],
                 e[W-1-:32], e[W-33-:32], e[W-65-:32], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    // reset and sequential fetch
    set_in(1, 1, 3'b000, 0, 0, 0, 0, 32'h80);
    step();
    chk("reset_pc", pc0, 32'h0);
    chk("reset_pend", {31'b0, pend0}, 32'h0);
    set_in(0, 1, 3'b000, 0, 0, 0, 0, 32'h80);
    step();
    step();
    chk("plus4_pc", pc0, 32'h8);
    chk("plus4_red", {31'b0, red0}, 32'h0);

    // branch
    set_in(0, 1, 3'b001, 32'h100, 32'h20, 0, 0, 32'h80);
    step();
    chk("branch_pc", pc0, 32'h120);
    chk("branch_red", {31'b0, red0}, 32'h1);
    set_in(0, 1, 3'b000, 0, 0, 0, 0, 32'h80);
    step();
    chk("branch_red_pulse", {31'b0, red0}, 32'h0);

    // JALR LSB clear / misalignment
    set_in(0, 1, 3'b100, 0, 0, 32'h203, 0, 32'h80);
    step();
    chk("jalr_a1_pc", pc1, 32'h202);
    chk("jalr_a2_pc", pc0, 32'h80);
    chk("jalr_a2_mis", {31'b0, mis0}, 32'h1);
    chk("jalr_a2_maddr", maddr0, 32'h202);
    set_in(0, 1, 3'b000, 0, 0, 0, 0, 32'h80);
    step();

    // stalled JUMP is kept pending
    set_in(0, 0, 3'b010, 32'h400, 32'h0, 0, 0, 32'h80);
    step();
    set_in(0, 0, 3'b000, 0, 0, 0, 0, 32'h80);
    step();
    step();
    chk("stall_pend", {31'b0, pend0}, 32'h1);
    set_in(0, 1, 3'b000, 0, 0, 0, 0, 32'h80);
    step();
    chk("release_pc", pc0, 32'h400);
    chk("release_red", {31'b0, red0}, 32'h1);
    chk("release_pend", {31'b0, pend0}, 32'h0);

    // trap overrides the pending jump
    set_in(0, 0, 3'b010, 32'h400, 32'h0, 0, 0, 32'h80);
    step();
    set_in(0, 0, 3'b000, 0, 0, 0, 1, 32'h80);
    step();
    set_in(0, 0, 3'b000, 0, 0, 0, 0, 32'h0);
    step();
    set_in(0, 1, 3'b000, 0, 0, 0, 0, 32'h0);
    step();
    chk("trap_over_pend_pc", pc0, 32'h80);

    // wrap
    set_in(0, 1, 3'b010, 32'h0, 32'hFFFF_FFFC, 0, 0, 32'h80);
    step();
    chk("wrap_p4", pcp0, 32'h0);
    set_in(0, 1, 3'b000, 0, 0, 0, 0, 32'h80);
    step();
    chk("wrap_pc", pc0, 32'h0);

    // reset mid-stall discards pending
    set_in(0, 0, 3'b010, 32'h0, 32'h40, 0, 0, 32'h80);
    step();
    set_in(1, 0, 3'b000, 0, 0, 0, 0, 32'h80);
    step();
    chk("rst_stall_pc", pc0, 32'h0);
    chk("rst_stall_pend", {31'b0, pend0}, 32'h0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      set_in(($urandom_range(0, 63) == 0),
             ($urandom_range(0, 3) != 0),
             3'($urandom_range(0, 7)),
             $urandom,
             ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & ~32'h3),
             ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & ~32'h2),
             ($urandom_range(0, 15) == 0),
             $urandom & ~32'h3);
      step();
    end

    tests_run++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      fail_cnt++;
      $display("FAIL sb_drain: got %0d/%0d entries left expected 0", exp_q0.size(), exp_q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
